dmem_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: M0, the core load/store path, and M1, a program-loader/debug port.
- Grants at most one transaction per cycle using round-robin priority.
- Supports a bounded lock (burst) so one requester can hold the port for back-to-back accesses.
- Sits between the requesters and Memory; read data returns one cycle after grant, matching Memory's registered read.

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_arbiter_if.sv | 28 ++
 rtl/dmem_arbiter_rr_pick2.sv | 23 ++
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   owner_e      : debug encoding of the current port owner
//   arb_state_e  : arbiter FSM state
//   DMEM_ADDR_W  : default byte-address width of the memory port
package dmem_pkg;

    localparam int DMEM_ADDR_W = 14;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_M0   = 2'b01,
        OWN_M1   = 2'b10
    } owner_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_e;

    function automatic owner_e state_to_owner(arb_state_e s);
        owner_e o;
        case (s)
            OWN0:    o = OWN_M0;
            OWN1:    o = OWN_M1;
            default: o = OWN_NONE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter (one instance per requester).
//   req/lock/we/addr/wdata : request, driven by the requester (master)
//   gnt                    : request accepted this cycle, driven by the arbiter
//   rvalid/rdata           : read return, one cycle after a granted read
interface dmem_arbiter_if
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W
);
    logic              req;
    logic              lock;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;

    modport master (
        output req, lock, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, lock, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-input round-robin selector.
//   req[1:0] : request vector (bit 0 = M0, bit 1 = M1)
//   ptr      : requester favoured on contention (0 = M0, 1 = M1)
//   gnt[1:0] : one-hot grant, or zero when nobody requests
module rr_pick2
    import dmem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one memory port between M0 (core load/store)
// and M1 (loader/debug) with round-robin priority and bounded locked bursts.
//   clk, rst            : system clock, asynchronous active-low reset
//   m0, m1              : requester buses (slave side)
//   mem_en/we/addr/wdata: memory access, muxed from the granted requester
//   mem_rdata           : memory registered read data (cycle after mem_en)
//   owner               : debug, 00 none / 01 M0 / 10 M1
//
// state | meaning
// IDLE  | no owner; grant by round robin between requesters
// OWN0  | M0 holds the port; only M0 may be granted
// OWN1  | M1 holds the port; only M1 may be granted
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = DMEM_ADDR_W,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     m0,
    dmem_arbiter_if.slave     m1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        owner
);

    localparam int             CNT_W    = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
    // With a one-grant burst limit a lock can never extend ownership.
    localparam bit             LOCK_OK  = (MAX_BURST > 1);

    arb_state_e       state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             rd_pend_q;
    logic             rd_sel_q;

    logic [1:0] pick_gnt;
    logic       gnt_m0, gnt_m1;
    logic       own_req, own_lock, own_gnt;

    rr_pick2 u_pick (
        .req ({m1.req, m0.req}),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt)
    );

    assign own_req  = (state_q == OWN1) ? m1.req  : m0.req;
    assign own_lock = (state_q == OWN1) ? m1.lock : m0.lock;
    assign own_gnt  = (state_q == OWN1) ? gnt_m1  : gnt_m0;

    always_comb begin
        gnt_m0      = 1'b0;
        gnt_m1      = 1'b0;
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;

        case (state_q)
            IDLE: begin
                gnt_m0 = pick_gnt[0];
                gnt_m1 = pick_gnt[1];
            end
            OWN0:    gnt_m0 = m0.req;
            OWN1:    gnt_m1 = m1.req;
            default: ;
        endcase

        // Grants are combinational, so they must be masked while reset is low.
        if (!rst) begin
            gnt_m0 = 1'b0;
            gnt_m1 = 1'b0;
        end

        if (gnt_m0) begin
            rr_ptr_d = 1'b1;
        end else if (gnt_m1) begin
            rr_ptr_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                burst_cnt_d = '0;
                // The entry grant is the first of the burst, so count from 1.
                if (LOCK_OK && gnt_m0 && m0.lock) begin
                    state_d     = OWN0;
                    burst_cnt_d = CNT_W'(1);
                end else if (LOCK_OK && gnt_m1 && m1.lock) begin
                    state_d     = OWN1;
                    burst_cnt_d = CNT_W'(1);
                end
            end
            OWN0, OWN1: begin
                if (!own_req || (own_gnt && (!own_lock || burst_cnt_q == LAST_CNT))) begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                end else if (own_gnt) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            burst_cnt_q <= '0;
            rd_pend_q   <= 1'b0;
            rd_sel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            rd_pend_q   <= mem_en & ~mem_we;
            rd_sel_q    <= gnt_m1;
        end
    end

    assign m0.gnt = gnt_m0;
    assign m1.gnt = gnt_m1;

    assign mem_en    = gnt_m0 | gnt_m1;
    assign mem_we    = gnt_m1 ? m1.we    : (gnt_m0 ? m0.we    : 1'b0);
    assign mem_addr  = gnt_m1 ? m1.addr  : (gnt_m0 ? m0.addr  : '0);
    assign mem_wdata = gnt_m1 ? m1.wdata : (gnt_m0 ? m0.wdata : '0);

    assign m0.rvalid = rd_pend_q & ~rd_sel_q;
    assign m1.rvalid = rd_pend_q &  rd_sel_q;
    assign m0.rdata  = m0.rvalid ? mem_rdata : 32'h0;
    assign m1.rdata  = m1.rvalid ? mem_rdata : 32'h0;

    assign owner = state_to_owner(state_q);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: randomized and directed traffic against a
// behavioural model, with a read-return scoreboard checked by a monitor.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int AW   = DMEM_ADDR_W;
    localparam int MAXB = 8;
    localparam int MEMN = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW)) m0_bus ();
    dmem_arbiter_if #(.ADDR_W(AW)) m1_bus ();

    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 32'h0;
    logic [1:0]    owner;

    dmem_arbiter #(.ADDR_W(AW), .MAX_BURST(MAXB)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0        (m0_bus),
        .m1        (m1_bus),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .owner     (owner)
    );

    function automatic logic [31:0] init_word(int i);
        return 32'hA500_0000 ^ 32'(i * 32'h0001_0003);
    endfunction

    // Memory device with a registered read port.
    logic [31:0] dev_mem [0:MEMN-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) dev_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= dev_mem[mem_addr];
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [0:MEMN-1];
    int m_owner;     // 0 none, 1 M0, 2 M1
    int m_run;       // grants taken in the current ownership
    int m_pref;      // requester that wins the next contention
    int m_last_win;  // requester granted last cycle, -1 if none

    typedef struct {
        int          id;
        logic [31:0] data;
        int          cyc;
    } rd_t;
    rd_t sb_q[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [1:0] last_gnt;

    // Stimulus held by each requester.
    logic          d_req   [2];
    logic          d_lock  [2];
    logic          d_we    [2];
    logic [AW-1:0] d_addr  [2];
    logic [31:0]   d_wdata [2];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic apply();
        m0_bus.req   = d_req[0];
        m0_bus.lock  = d_lock[0];
        m0_bus.we    = d_we[0];
        m0_bus.addr  = d_addr[0];
        m0_bus.wdata = d_wdata[0];
        m1_bus.req   = d_req[1];
        m1_bus.lock  = d_lock[1];
        m1_bus.we    = d_we[1];
        m1_bus.addr  = d_addr[1];
        m1_bus.wdata = d_wdata[1];
    endtask

    function automatic int model_pick();
        int x;
        if (m_owner == 0) begin
            if (d_req[0] && d_req[1]) return m_pref;
            if (d_req[0]) return 0;
            if (d_req[1]) return 1;
            return -1;
        end
        x = m_owner - 1;
        return d_req[x] ? x : -1;
    endfunction

    task automatic model_commit(int win);
        if (win >= 0) begin
            if (d_we[win]) ref_mem[d_addr[win]] = d_wdata[win];
            else sb_q.push_back('{win, ref_mem[d_addr[win]], cyc});
            m_pref = 1 - win;
            if (m_owner == 0) begin
                if (d_lock[win] && MAXB > 1) begin
                    m_owner = win + 1;
                    m_run   = 1;
                end
            end else begin
                m_run++;
                if (!d_lock[win] || m_run >= MAXB) m_owner = 0;
            end
        end else if (m_owner != 0) begin
            m_owner = 0;  // owner stopped requesting
        end
        m_last_win = win;
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_owner    = 0;
        m_run      = 0;
        m_pref     = 0;
        m_last_win = -1;
    endtask

    // One cycle: starts just after a rising edge with d_* set up.
    task automatic step();
        int win;
        logic [1:0] exp_gnt;
        apply();
        win = model_pick();
        exp_gnt = (win == 0) ? 2'b01 : (win == 1) ? 2'b10 : 2'b00;
        #3;
        check("gnt", {m1_bus.gnt, m0_bus.gnt}, exp_gnt);
        check("owner", owner, m_owner);
        check("mem_en", mem_en, win >= 0);
        if (win >= 0)
            check("mem_bus", {mem_we, mem_addr, mem_wdata},
                  {d_we[win], d_addr[win], d_wdata[win]});
        last_gnt = {m1_bus.gnt, m0_bus.gnt};
        model_commit(win);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Random transaction generator honouring the hold-until-grant rule.
    task automatic gen(int x, int p_req, int p_lock, int p_we, int base, int mask, int p_drop);
        if (m_last_win == x || !d_req[x]) begin
            d_req[x]   = $urandom_range(99) < p_req;
            d_lock[x]  = $urandom_range(99) < p_lock;
            d_we[x]    = $urandom_range(99) < p_we;
            d_addr[x]  = AW'(base + int'($urandom & mask));
            d_wdata[x] = $urandom;
        end else if ($urandom_range(99) < p_drop) begin
            d_req[x] = 1'b0;
        end
    endtask

    task automatic set_txn(int x, logic req, logic lock, logic we, int addr, logic [31:0] wdata);
        d_req[x]   = req;
        d_lock[x]  = lock;
        d_we[x]    = we;
        d_addr[x]  = AW'(addr);
        d_wdata[x] = wdata;
    endtask

    // Reset with both requesters asserting; leaves both requesting unlocked reads.
    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        set_txn(0, 1'b1, 1'b0, 1'b0, 'h10, 32'h0);
        set_txn(1, 1'b1, 1'b0, 1'b0, 'h20, 32'h0);
        apply();
        #2;
        check("rst_gnt", {m1_bus.gnt, m0_bus.gnt}, 2'b00);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_rvalid", {m1_bus.rvalid, m0_bus.rvalid}, 2'b00);
        check("rst_owner", owner, 2'b00);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_gnt_hold", {m1_bus.gnt, m0_bus.gnt}, 2'b00);
        rst = 1'b1;
        cyc++;
    endtask

    // Read-return monitor.
    always @(negedge clk) begin
        rd_t e;
        if (rst) begin
            if (m0_bus.rvalid || m1_bus.rvalid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rvalid_unexpected cyc=%0d actual=%b%b required=00",
                             cyc, m1_bus.rvalid, m0_bus.rvalid);
                end else begin
                    e = sb_q.pop_front();
                    check("rvalid_id", {m1_bus.rvalid, m0_bus.rvalid}, (e.id == 1) ? 2'b10 : 2'b01);
                    check("rvalid_lat", e.cyc, cyc - 1);
                    check("rdata", (e.id == 1) ? m1_bus.rdata : m0_bus.rdata, e.data);
                    check("rdata_other", (e.id == 1) ? m0_bus.rdata : m1_bus.rdata, 32'h0);
                end
            end else if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                e = sb_q.pop_front();
                checks++;
                errors++;
                $display("FAIL rvalid_missing cyc=%0d actual=0 required=1 (M%0d)", cyc, e.id);
            end
        end
    end

    initial begin
        int m1_run;
        bit seen_m0;

        for (int i = 0; i < MEMN; i++) begin
            dev_mem[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        set_txn(0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
        set_txn(1, 1'b0, 1'b0, 1'b0, 0, 32'h0);
        apply();
        @(posedge clk);
        #1;

        // Reset, then contention of unlocked reads: M0 first, then alternate.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            gen(0, 100, 0, 0, 'h10, 0, 0);
            gen(1, 100, 0, 0, 'h20, 0, 0);
            step();
            check("alternate", last_gnt, (i % 2 == 1) ? 2'b10 : 2'b01);
        end

        // Locked burst by M1 with M0 waiting: forced release after MAXB grants.
        do_reset();
        set_txn(0, 1'b0, 1'b0, 1'b0, 'h30, 32'h0);
        set_txn(1, 1'b1, 1'b1, 1'b1, 'h100, $urandom);
        m1_run  = 0;
        seen_m0 = 0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin
                gen(0, 100, 0, 0, 'h30, 0, 0);
                gen(1, 100, 100, 100, 'h100, 'hFC, 0);
            end
            step();
            if (!seen_m0) begin
                if (last_gnt == 2'b10) m1_run++;
                else if (last_gnt == 2'b01) seen_m0 = 1;
            end
        end
        check("burst_len", {31'(seen_m0), 32'(m1_run)}, {31'd1, 32'(MAXB)});

        // Early unlock: M0 locks three grants, drops lock on the fourth.
        do_reset();
        set_txn(1, 1'b1, 1'b0, 1'b0, 'h84, 32'h0);
        for (int i = 0; i < 4; i++) begin
            set_txn(0, 1'b1, i < 3, 1'b1, 'h80 + 4 * i, $urandom);
            step();
            check("unlock_m0_gnt", last_gnt, 2'b01);
        end
        set_txn(0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
        step();
        check("unlock_m1_next", last_gnt, 2'b10);
        set_txn(1, 1'b0, 1'b0, 1'b0, 0, 32'h0);
        step();

        // Write by M0 then read-back by M1.
        set_txn(0, 1'b1, 1'b0, 1'b1, 'h40, 32'hDEAD_BEEF);
        step();
        set_txn(0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
        set_txn(1, 1'b1, 1'b0, 1'b0, 'h40, 32'h0);
        step();
        set_txn(1, 1'b0, 1'b0, 1'b0, 0, 32'h0);
        step();
        step();

        // Asynchronous reset in the middle of an M0 burst.
        do_reset();
        set_txn(1, 1'b1, 1'b0, 1'b0, 'h24, 32'h0);
        for (int i = 0; i < 3; i++) begin
            set_txn(0, 1'b1, 1'b1, 1'b1, 'h200 + 4 * i, $urandom);
            step();
        end
        check("mid_owner_pre", owner, 2'b01);
        #1;
        rst = 1'b0;
        #1;
        check("async_owner", owner, 2'b00);
        check("async_gnt", {m1_bus.gnt, m0_bus.gnt}, 2'b00);
        check("async_mem_en", mem_en, 1'b0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc++;
        set_txn(0, 1'b1, 1'b1, 1'b1, 'h300, $urandom);
        set_txn(1, 1'b1, 1'b1, 1'b1, 'h380, $urandom);
        for (int i = 0; i < 20; i++) begin
            gen(0, 100, 100, 100, 'h300, 'h3C, 0);
            gen(1, 100, 100, 100, 'h380, 'h3C, 0);
            step();
        end

        // Randomized mixed traffic on a shared address window.
        for (int i = 0; i < 600; i++) begin
            gen(0, 70, 35, 40, 'h40, 'h3C, 4);
            gen(1, 60, 45, 50, 'h40, 'h3C, 4);
            step();
        end

        set_txn(0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
        set_txn(1, 1'b0, 1'b0, 1'b0, 0, 32'h0);
        for (int i = 0; i < 3; i++) step();
        check("sb_drain", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
